// File: rtl/spi_master_shifter.sv
// SPI master shift engine: serialises one DATA_WIDTH word per transfer against an
// externally generated sck, in any of the four SPI modes, MSB- or LSB-first.
module spi_master_shifter #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic                  sck,
    output logic                  clk_en,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  ss_n,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [CntW-1:0] LastEdge = CntW'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StXfer, StDone} state_e;

    state_e                state;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [DATA_WIDTH-1:0] tx_shifted;
    logic [CntW-1:0]       edge_cnt;
    logic                  cpol_l;
    logic                  cpha_l;
    logic                  lsb_l;
    logic                  sck_q;
    logic                  mosi_q;
    logic                  ss_n_q;
    logic                  rx_valid_q;

    logic edge_det;
    logic leading;
    logic sample;
    logic drive;
    logic last_edge;
    logic next_bit;

    always_comb begin
        edge_det   = (state == StXfer) && (sck != sck_q);
        leading    = (sck_q == cpol_l);
        sample     = edge_det && (cpha_l ? !leading : leading);
        // Mode 0/2 drives on trailing edges, but the final trailing edge has no next bit.
        drive      = edge_det && (cpha_l ? leading : (!leading && (edge_cnt != LastEdge)));
        last_edge  = edge_det && (edge_cnt == LastEdge);
        rx_next    = lsb_l ? {miso, rx_sh[DATA_WIDTH-1:1]} : {rx_sh[DATA_WIDTH-2:0], miso};
        next_bit   = lsb_l ? tx_sh[0] : tx_sh[DATA_WIDTH-1];
        tx_shifted = lsb_l ? (tx_sh >> 1) : (tx_sh << 1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= StIdle;
            tx_sh      <= '0;
            rx_sh      <= '0;
            rx_data    <= '0;
            edge_cnt   <= '0;
            cpol_l     <= 1'b0;
            cpha_l     <= 1'b0;
            lsb_l      <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            rx_valid_q <= 1'b0;
        end else begin
            sck_q      <= sck;
            rx_valid_q <= 1'b0;
            case (state)
                StIdle: begin
                    if (tx_valid) begin
                        tx_sh    <= tx_data;
                        cpol_l   <= cpol;
                        cpha_l   <= cpha;
                        lsb_l    <= lsb_first;
                        edge_cnt <= '0;
                        rx_sh    <= '0;
                        ss_n_q   <= 1'b0;
                        state    <= StSetup;
                    end
                end
                StSetup: begin
                    if (!cpha_l) begin
                        mosi_q <= next_bit;
                        tx_sh  <= tx_shifted;
                    end
                    state <= StXfer;
                end
                StXfer: begin
                    if (edge_det) begin
                        edge_cnt <= edge_cnt + 1'b1;
                    end
                    if (sample) begin
                        rx_sh <= rx_next;
                    end
                    if (drive) begin
                        mosi_q <= next_bit;
                        tx_sh  <= tx_shifted;
                    end
                    // Load rx_data here so the word and its valid pulse coincide with DONE.
                    if (last_edge) begin
                        rx_data    <= sample ? rx_next : rx_sh;
                        rx_valid_q <= 1'b1;
                        ss_n_q     <= 1'b1;
                        state      <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign tx_ready = (state == StIdle);
    assign busy     = (state != StIdle);
    assign clk_en   = (state == StXfer);
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: models the sck generator and an SPI slave, and checks
// serial order, received words and handshake against the mode rules.
module tb_spi_master_shifter;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         cpol = 1'b0;
    logic         cpha = 1'b0;
    logic         lsb_first = 1'b0;
    logic         sck;
    logic         miso;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         clk_en;
    logic         mosi;
    logic         ss_n;
    logic         busy;

    int tests = 0;
    int fails = 0;

    // Clock generator / slave configuration, independent of the DUT's cpol/cpha inputs.
    logic         g_cpol = 1'b0;
    logic         g_cpha = 1'b0;
    logic         g_lsb = 1'b0;
    logic         loop = 1'b0;
    logic [W-1:0] slave_word = '0;
    logic         slave_bit;
    int           hc = 0;
    int           n_edges = 0;
    int           xfer_edges = 0;
    logic         mosi_bits[$];

    spi_master_shifter #(.DATA_WIDTH(W)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .cpol     (cpol),
        .cpha     (cpha),
        .lsb_first(lsb_first),
        .sck      (sck),
        .clk_en   (clk_en),
        .mosi     (mosi),
        .miso     (miso),
        .ss_n     (ss_n),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    assign miso = loop ? mosi : slave_bit;

    function automatic logic word_bit(input logic [W-1:0] w, input int k, input logic lsb);
        return lsb ? w[k] : w[W-1-k];
    endfunction

    // sck half period = 2 CLK cycles; slave records mosi on its sampling edges.
    always @(negedge CLK) begin
        if (!clk_en) begin
            sck       = g_cpol;
            hc        = 0;
            n_edges   = 0;
            slave_bit = word_bit(slave_word, 0, g_lsb);
        end else begin
            hc++;
            if (hc == 2) begin
                hc = 0;
                n_edges++;
                xfer_edges++;
                if (g_cpha ? (n_edges % 2 == 0) : (n_edges % 2 == 1)) mosi_bits.push_back(mosi);
                sck = ~sck;
                if (!g_cpha && (n_edges % 2 == 0) && (n_edges < 2 * W))
                    slave_bit = word_bit(slave_word, n_edges / 2, g_lsb);
                if (g_cpha && (n_edges % 2 == 1))
                    slave_bit = word_bit(slave_word, (n_edges - 1) / 2, g_lsb);
            end
        end
    end

    task automatic configure(input logic pol, input logic pha, input logic lsb, input logic lp,
                             input logic [W-1:0] sw);
        @(negedge CLK);
        g_cpol = pol; g_cpha = pha; g_lsb = lsb; loop = lp; slave_word = sw;
        cpol = pol; cpha = pha; lsb_first = lsb;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic start_xfer(input logic [W-1:0] d, input logic pol, input logic pha,
                              input logic lsb, input logic lp, input logic [W-1:0] sw);
        configure(pol, pha, lsb, lp, sw);
        mosi_bits.delete();
        xfer_edges = 0;
        tx_data    = d;
        tx_valid   = 1'b1;
        @(negedge CLK);
        tx_valid   = 1'b0;
    endtask

    task automatic finish_xfer(input string name, input logic [W-1:0] exp_rx,
                               input logic [W-1:0] exp_tx, input logic lsb);
        int           cyc = 0;
        int           overlap = 0;
        bit           got = 0;
        logic [W-1:0] mw;
        while (!got && cyc < 400) begin
            @(negedge CLK);
            cyc++;
            if (busy && tx_ready) overlap++;
            if (rx_valid) got = 1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s rx_valid timeout: got none, required a pulse within 400 cycles", name);
        end else begin
            tests++;
            if (rx_data !== exp_rx) begin
                fails++;
                $display("FAIL %s rx_data: got %h, required %h", name, rx_data, exp_rx);
            end
            tests++;
            if (ss_n !== 1'b1 || clk_en !== 1'b0) begin
                fails++;
                $display("FAIL %s done state: ss_n=%b clk_en=%b, required 1 0", name, ss_n, clk_en);
            end
        end
        tests++;
        if (xfer_edges != 2 * W) begin
            fails++;
            $display("FAIL %s sck edges: got %0d, required %0d", name, xfer_edges, 2 * W);
        end
        mw = '0;
        for (int i = 0; i < mosi_bits.size() && i < W; i++) begin
            if (lsb) mw[i] = mosi_bits[i];
            else mw[W-1-i] = mosi_bits[i];
        end
        tests++;
        if (mosi_bits.size() != W || mw !== exp_tx) begin
            fails++;
            $display("FAIL %s mosi serial: got %h (%0d bits), required %h (%0d bits)",
                     name, mw, mosi_bits.size(), exp_tx, W);
        end
        tests++;
        if (overlap != 0) begin
            fails++;
            $display("FAIL %s tx_ready while busy: got %0d cycles, required 0", name, overlap);
        end
        @(negedge CLK);
        tests++;
        if (rx_valid !== 1'b0 || tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s after done: rx_valid=%b tx_ready=%b, required 0 1",
                     name, rx_valid, tx_ready);
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || clk_en !== 1'b0) begin
            fails++;
            $display("FAIL reset ctrl: tx_ready=%b busy=%b clk_en=%b, required 1 0 0",
                     tx_ready, busy, clk_en);
        end
        tests++;
        if (ss_n !== 1'b1 || mosi !== 1'b0) begin
            fails++;
            $display("FAIL reset pins: ss_n=%b mosi=%b, required 1 0", ss_n, mosi);
        end
        tests++;
        if (rx_data !== '0 || rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset rx: rx_data=%h rx_valid=%b, required 00 0", rx_data, rx_valid);
        end
    endtask

    task automatic test_mode0();
        start_xfer(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        finish_xfer("mode0_a5", 8'hA5, 8'hA5, 1'b0);
    endtask

    task automatic test_mode3();
        configure(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
        tests++;
        if (sck !== 1'b1) begin
            fails++;
            $display("FAIL mode3 sck idle before: got %b, required 1", sck);
        end
        start_xfer(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
        finish_xfer("mode3_3c", 8'hFF, 8'h3C, 1'b1);
        tests++;
        if (sck !== 1'b1) begin
            fails++;
            $display("FAIL mode3 sck idle after: got %b, required 1", sck);
        end
    endtask

    task automatic test_back_to_back();
        int          cyc = 0;
        int          gap = 0;
        int          overlap = 0;
        int          n_rx = 0;
        logic [W-1:0] rx_seen[2];
        configure(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        @(negedge CLK);
        tx_data  = 8'h80;
        while (n_rx < 2 && cyc < 800) begin
            @(negedge CLK);
            cyc++;
            if (busy && tx_ready) overlap++;
            if (rx_valid) begin
                rx_seen[n_rx] = rx_data;
                n_rx++;
                if (n_rx == 1) begin
                    while (ss_n === 1'b1 && gap < 20) begin
                        gap++;
                        @(negedge CLK);
                    end
                    tx_valid = 1'b0;
                end
            end
        end
        tx_valid = 1'b0;
        tests++;
        if (n_rx != 2) begin
            fails++;
            $display("FAIL b2b pulses: got %0d, required 2", n_rx);
        end else begin
            tests++;
            if (rx_seen[0] !== 8'h01 || rx_seen[1] !== 8'h80) begin
                fails++;
                $display("FAIL b2b order: got %h %h, required 01 80", rx_seen[0], rx_seen[1]);
            end
        end
        tests++;
        if (gap < 1 || gap >= 20) begin
            fails++;
            $display("FAIL b2b ss_n gap: got %0d cycles, required 1..19", gap);
        end
        tests++;
        if (overlap != 0) begin
            fails++;
            $display("FAIL b2b tx_ready while busy: got %0d cycles, required 0", overlap);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        int pulses = 0;
        start_xfer(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        while (xfer_edges < 5 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        tests++;
        if (xfer_edges < 5) begin
            fails++;
            $display("FAIL rst_mid edges: got %0d, required 5", xfer_edges);
        end
        nRST = 1'b0;
        #1;
        tests++;
        if (ss_n !== 1'b1 || clk_en !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid abort: ss_n=%b clk_en=%b tx_ready=%b rx_valid=%b, required 1 0 1 0",
                     ss_n, clk_en, tx_ready, rx_valid);
        end
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (rx_valid) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL rst_mid stray rx_valid: got %0d, required 0", pulses);
        end
        start_xfer(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        finish_xfer("rst_mid_5a", 8'h5A, 8'h5A, 1'b0);
    endtask

    task automatic test_config_change();
        int cyc = 0;
        start_xfer(8'hC3, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        while (xfer_edges < 6 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        cpol      = 1'b1;
        lsb_first = 1'b1;
        finish_xfer("cfg_change_c3", 8'hC3, 8'hC3, 1'b0);
        cpol      = 1'b0;
        lsb_first = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] d;
            logic [W-1:0] sw;
            logic         pol;
            logic         pha;
            logic         lsb;
            d   = W'($urandom);
            sw  = W'($urandom);
            pol = 1'($urandom_range(0, 1));
            pha = 1'($urandom_range(0, 1));
            lsb = 1'($urandom_range(0, 1));
            start_xfer(d, pol, pha, lsb, 1'b0, sw);
            finish_xfer($sformatf("rand%0d_m%0d%0d_l%0d", i, pol, pha, lsb), sw, d, lsb);
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        test_reset();
        nRST = 1'b1;
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_reset_mid();
        test_config_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_master_shifter.md
SPI_MASTER_SHIFTER -- requirements
Module: spi_master_shifter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning bits per transfer (legal range 2..32).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: CLK (input, 1, system clock) and nRST (input, 1, asynchronous active-low reset).
REQ-003 tx_data  input  DATA_WIDTH  byte to transmit.
REQ-004 tx_valid  input  1  tx_data valid.
REQ-005 tx_ready  output  1  block accepts tx_data this cycle.
REQ-006 rx_data  output  DATA_WIDTH  last received word.
REQ-007 rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-008 cpol, cpha, lsb_first  input  1 each  SPI mode and bit order.
REQ-009 sck  input  1  serial clock from the upstream clock generator, whose output holds polarity while disabled.
REQ-010 clk_en  output  1  enable to the clock generator.
REQ-011 mosi  output  1; miso  input  1; ss_n  output  1, active-low slave select.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, SETUP, XFER and DONE.
REQ-014 tx_ready SHALL be 1 only in IDLE; a transfer is accepted on a cycle where tx_valid=1 and tx_ready=1.
REQ-015 On accept, the block SHALL latch tx_data, cpol, cpha and lsb_first, clear the edge counter and rx shift register, set ss_n=0, and go to SETUP next cycle; later input changes SHALL be ignored until the next accept.
REQ-016 In SETUP (exactly 1 cycle), if cpha=0 the block SHALL drive the first bit on mosi (MSB if lsb_first=0, else LSB); clk_en SHALL be 0. The next state SHALL be XFER.
REQ-017 In XFER, clk_en SHALL be 1.
REQ-018 The block SHALL register sck every cycle as sck_q; an edge is sck != sck_q while in XFER. A leading edge is sck_q == latched cpol; a trailing edge is the opposite.
REQ-019 cpha=0: the block SHALL sample miso on leading edges and drive the next bit on trailing edges, skipping the final trailing edge.
REQ-020 cpha=1: the block SHALL drive a bit on each leading edge (the first leading edge drives the first bit) and sample miso on trailing edges.
REQ-021 Sample direction: lsb_first=0 shifts left, rx = {rx[W-2:0], miso}; lsb_first=1 shifts right, rx = {miso, rx[W-1:1]}.
REQ-022 The edge counter SHALL be ceil(log2(2*DATA_WIDTH+1)) bits wide; after the 2*DATA_WIDTH-th edge the block SHALL go to DONE next cycle.
REQ-023 In DONE (exactly 1 cycle): clk_en=0, ss_n=1, rx_data <= rx shift register, rx_valid=1; then IDLE.
REQ-024 ss_n SHALL therefore be high for at least 1 cycle (DONE) between back-to-back transfers.
REQ-025 rx_valid has no backpressure; an unobserved pulse is lost, and rx_data holds until the next DONE.
REQ-026 mosi SHALL hold its last driven value between edges and in IDLE.
REQ-027 Edges outside XFER SHALL be ignored.

Reset
REQ-028 While nRST=0, asynchronously: state=IDLE, tx_ready=1, rx_data=0, rx_valid=0, clk_en=0, ss_n=1, mosi=0, busy=0, counters=0, sck_q=0.
REQ-029 Reset mid-transfer SHALL abort the transfer with no rx_valid pulse; the first post-reset accept SHALL behave as from power-up.

Verification
REQ-030 Mode 0 (cpol=0, cpha=0), MSB-first, tx_data=0xA5, miso looped to mosi -> mosi shows 1,0,1,0,0,1,0,1; 16 sck edges; single rx_valid pulse with rx_data=0xA5; ss_n=1 afterwards.
REQ-031 Mode 3 (cpol=1, cpha=1), lsb_first=1, tx_data=0x3C, miso=1 -> mosi shows 0,0,1,1,1,1,0,0; rx_data=0xFF; sck idles high before and after the transfer.
REQ-032 tx_valid held high with 0x01 then 0x80 -> two transfers, tx_ready=0 throughout busy, ss_n high for >=1 cycle between them, rx_valid pulses in order.
REQ-033 nRST asserted after 5 edges of a 0xFF transfer -> same cycle: ss_n=1, clk_en=0, tx_ready=1; no rx_valid; the next transfer of 0x5A loopback returns 0x5A.
REQ-034 cpol and lsb_first toggled mid-transfer (Mode 1, tx_data=0xC3) -> captured bits and rx_data=0xC3 are unaffected.
